// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between up to four requesters and the writeback arbiter.
//   req_valid : per-requester request (bit i = requester i)
//   req_addr  : destination register address, requester i at [i*ADDR_LEN +: ADDR_LEN]
//   req_data  : write data, packed like req_addr
//   req_ready : grant back to each requester (combinational in the arbiter)
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDR_LEN = `ADDR_LEN,
  parameter int unsigned DATA_LEN = `DATA_LEN
);
  logic [3:0]            req_valid;
  logic [4*ADDR_LEN-1:0] req_addr;
  logic [4*DATA_LEN-1:0] req_data;
  logic [3:0]            req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for a 2-write-port register file.
// Grants up to two requesters per cycle, registers them onto the two write
// ports, forwards in-flight writes to two read ports and counts stall cycles.
//   clk, reset         : clock, asynchronous active-low reset
//   req (slave)        : four-requester writeback bus (valid/addr/data/ready)
//   flush              : block all new grants this cycle
//   we/waddr/wdata 1,2 : registered register-file write ports
//   rd_addr1/2         : register-file read addresses this cycle
//   rd_hit1/2, rd_fwd1/2 : forwarding of the registered writes to the readers
//   stall_cnt, stall_clr : saturating stall-cycle counter and its clear
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module regfile_wb_arbiter #(
  parameter int unsigned ADDR_LEN = `ADDR_LEN,
  parameter int unsigned DATA_LEN = `DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave req,
  input  logic                flush,
  output logic                we1,
  output logic [ADDR_LEN-1:0] waddr1,
  output logic [DATA_LEN-1:0] wdata1,
  output logic                we2,
  output logic [ADDR_LEN-1:0] waddr2,
  output logic [DATA_LEN-1:0] wdata2,
  input  logic [ADDR_LEN-1:0] rd_addr1,
  input  logic [ADDR_LEN-1:0] rd_addr2,
  output logic                rd_hit1,
  output logic                rd_hit2,
  output logic [DATA_LEN-1:0] rd_fwd1,
  output logic [DATA_LEN-1:0] rd_fwd2,
  output logic [15:0]         stall_cnt,
  input  logic                stall_clr
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 16;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_ptr_nxt;
  logic [ADDR_LEN-1:0] addr_a [NREQ];
  logic [DATA_LEN-1:0] data_a [NREQ];

  logic                s1_vld;
  logic                s2_vld;
  logic [PTR_W-1:0]    s1_idx;
  logic [PTR_W-1:0]    s2_idx;
  logic [ADDR_LEN-1:0] s1_addr;
  logic [ADDR_LEN-1:0] s2_addr;
  logic [DATA_LEN-1:0] s1_data;
  logic [DATA_LEN-1:0] s2_data;
  logic [NREQ-1:0]     grant;
  logic                stall_c;

  // Unpack the flat requester buses.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = req.req_addr[i*ADDR_LEN +: ADDR_LEN];
      data_a[i] = req.req_data[i*DATA_LEN +: DATA_LEN];
    end
  end

  // Round-robin scan from rr_ptr filling slot 1 then slot 2.
  // A second request to slot 1's address waits, except address 0 which never writes.
  always_comb begin
    logic [PTR_W-1:0] idx;
    s1_vld     = 1'b0;
    s2_vld     = 1'b0;
    s1_idx     = '0;
    s2_idx     = '0;
    s1_addr    = '0;
    s2_addr    = '0;
    s1_data    = '0;
    s2_data    = '0;
    grant      = '0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + PTR_W'(k);
      if (!flush && req.req_valid[idx]) begin
        if (!s1_vld) begin
          s1_vld      = 1'b1;
          s1_idx      = idx;
          s1_addr     = addr_a[idx];
          s1_data     = data_a[idx];
          grant[idx]  = 1'b1;
        end else if (!s2_vld && ((addr_a[idx] != s1_addr) || (addr_a[idx] == '0))) begin
          s2_vld      = 1'b1;
          s2_idx      = idx;
          s2_addr     = addr_a[idx];
          s2_data     = data_a[idx];
          grant[idx]  = 1'b1;
        end
      end
    end
    if (s2_vld) begin
      rr_ptr_nxt = s2_idx + PTR_W'(1);
    end else if (s1_vld) begin
      rr_ptr_nxt = s1_idx + PTR_W'(1);
    end
  end

  // Grants are held off entirely while reset is asserted.
  assign req.req_ready = reset ? grant : '0;
  assign stall_c       = |(req.req_valid & ~req.req_ready);

  // Write-port registers, round-robin pointer and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we1       <= 1'b0;
      waddr1    <= '0;
      wdata1    <= '0;
      we2       <= 1'b0;
      waddr2    <= '0;
      wdata2    <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      we1 <= s1_vld && (s1_addr != '0);
      we2 <= s2_vld && (s2_addr != '0);
      if (s1_vld) begin
        waddr1 <= s1_addr;
        wdata1 <= s1_data;
      end
      if (s2_vld) begin
        waddr2 <= s2_addr;
        wdata2 <= s2_data;
      end
      rr_ptr <= rr_ptr_nxt;
      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Forward registered writes to read port 1 (slots never share a nonzero address).
  always_comb begin
    rd_hit1 = 1'b0;
    rd_fwd1 = '0;
    if (rd_addr1 != '0) begin
      if (we1 && (waddr1 == rd_addr1)) begin
        rd_hit1 = 1'b1;
        rd_fwd1 = wdata1;
      end else if (we2 && (waddr2 == rd_addr1)) begin
        rd_hit1 = 1'b1;
        rd_fwd1 = wdata2;
      end
    end
  end

  // Forward registered writes to read port 2.
  always_comb begin
    rd_hit2 = 1'b0;
    rd_fwd2 = '0;
    if (rd_addr2 != '0) begin
      if (we1 && (waddr1 == rd_addr2)) begin
        rd_hit2 = 1'b1;
        rd_fwd2 = wdata1;
      end else if (we2 && (waddr2 == rd_addr2)) begin
        rd_hit2 = 1'b1;
        rd_fwd2 = wdata2;
      end
    end
  end

endmodule
